// File: rtl/complex_mixer_tdm.sv
// complex_mixer_tdm: time-multiplexed complex mixer, out = in * lo (or in * conj(lo)).
// One shared DSZ x DSZ multiplier produces the four partial products over four
// phases; results are rounded half-up and saturated back to DSZ bits.
// Optional feature macro: COMPLEX_MIXER_CONJ_EN (when undefined, conj is ignored).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   input handshake (accept = in_valid && in_ready)
//   in_ch                 channel tag carried alongside the sample
//   in_i, in_q            signed input sample
//   lo_i, lo_q            signed LO sample
//   conj                  1: in*conj(lo), 0: in*lo (captured on accept)
//   out_valid             one-cycle result strobe, 6 cycles after accept
//   out_ch, out_i, out_q  result tag and value, held between strobes
module complex_mixer_tdm #(
    parameter int unsigned DSZ = 16,
    parameter int unsigned NCH = 2,
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CHW-1:0]        in_ch,
    input  logic signed [DSZ-1:0] in_i,
    input  logic signed [DSZ-1:0] in_q,
    input  logic signed [DSZ-1:0] lo_i,
    input  logic signed [DSZ-1:0] lo_q,
    input  logic                  conj,
    output logic                  out_valid,
    output logic [CHW-1:0]        out_ch,
    output logic signed [DSZ-1:0] out_i,
    output logic signed [DSZ-1:0] out_q
);
    localparam int unsigned PW = 2 * DSZ;
    localparam int unsigned AW = 2 * DSZ + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PH0  = 3'd1;
    localparam logic [2:0] S_PH1  = 3'd2;
    localparam logic [2:0] S_PH2  = 3'd3;
    localparam logic [2:0] S_PH3  = 3'd4;

    localparam logic signed [AW:0] RND  = $signed((AW+1)'(2 ** (DSZ - 2)));
    localparam logic signed [AW:0] SMAX = $signed((AW+1)'((2 ** (DSZ - 1)) - 1));
    localparam logic signed [AW:0] SMIN = -SMAX - $signed((AW+1)'(1));

    logic [2:0]            state, state_nxt;
    logic                  accept;
    logic                  conj_eff;
    logic signed [DSZ-1:0] a_i, a_q, b_i, b_q;
    logic [CHW-1:0]        ch_buf, fin_ch;
    logic                  conj_buf;
    logic signed [DSZ-1:0] mul_a, mul_b;
    logic [1:0]            mul_ph, prod_ph;
    logic signed [PW-1:0]  prod;
    logic                  prod_vld;
    logic signed [AW-1:0]  acc_i, acc_q, q_fin;

`ifdef COMPLEX_MIXER_CONJ_EN
    assign conj_eff = conj;
`else
    logic conj_unused;
    assign conj_unused = conj;
    assign conj_eff    = 1'b0;
`endif

    // Round half up at the DSZ-1 binary point, then clamp to DSZ bits.
    function automatic logic signed [DSZ-1:0] rnd_sat(input logic signed [AW-1:0] acc);
        logic signed [AW:0] t;
        t = (AW+1)'(acc) + RND;
        t = t >>> (DSZ - 1);
        if (t > SMAX)      t = SMAX;
        else if (t < SMIN) t = SMIN;
        return DSZ'(t);
    endfunction

    assign in_ready = ((state == S_IDLE) || (state == S_PH3)) && !reset;
    assign accept   = in_valid && in_ready;

    // Phase sequencer: a new sample may only be taken from IDLE or PH3.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_PH0;
            S_PH0:   state_nxt = S_PH1;
            S_PH1:   state_nxt = S_PH2;
            S_PH2:   state_nxt = S_PH3;
            S_PH3:   state_nxt = accept ? S_PH0 : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand selection for the shared multiplier.
    always_comb begin
        mul_a  = a_i;
        mul_b  = b_i;
        mul_ph = 2'd0;
        case (state)
            S_PH1: begin mul_a = a_q; mul_b = b_q; mul_ph = 2'd1; end
            S_PH2: begin mul_a = a_i; mul_b = b_q; mul_ph = 2'd2; end
            S_PH3: begin mul_a = a_q; mul_b = b_i; mul_ph = 2'd3; end
            default: ;
        endcase
    end

    // Final Q term arrives in the cycle after PH3 and is folded in directly.
    assign q_fin = acc_q + AW'(prod);

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            prod_vld  <= 1'b0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_i     <= '0;
            out_q     <= '0;
        end else begin
            state     <= state_nxt;
            prod_vld  <= (state != S_IDLE);
            out_valid <= prod_vld && (prod_ph == 2'd3);
            if (prod_vld && (prod_ph == 2'd3)) begin
                out_ch <= fin_ch;
                out_i  <= rnd_sat(acc_i);
                out_q  <= rnd_sat(q_fin);
            end
        end
    end

    // Datapath: operand buffers, product register and accumulators.
    // Operand buffers are overwritten at the end of PH3, after their last use;
    // the tag is copied to fin_ch so it survives until the output cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_i      <= in_i;
            a_q      <= in_q;
            b_i      <= lo_i;
            b_q      <= lo_q;
            ch_buf   <= in_ch;
            conj_buf <= conj_eff;
        end
        if (state == S_PH3) fin_ch <= ch_buf;
        prod    <= PW'(mul_a * mul_b);
        prod_ph <= mul_ph;
        if (prod_vld) begin
            case (prod_ph)
                2'd0: acc_i <= AW'(prod);
                2'd1: acc_i <= conj_buf ? acc_i + AW'(prod) : acc_i - AW'(prod);
                2'd2: acc_q <= conj_buf ? -AW'(prod) : AW'(prod);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_complex_mixer_tdm.sv
// Self-checking bench for complex_mixer_tdm (DSZ=16, NCH=2): directed cases with
// literal expectations, continuous-valid streaming, random traffic, mid-run reset.
module tb_complex_mixer_tdm;
    localparam int DSZ = 16;
    localparam int CHW = 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [CHW-1:0]        in_ch;
    logic signed [DSZ-1:0] in_i, in_q, lo_i, lo_q;
    logic                  conj;
    logic                  out_valid;
    logic [CHW-1:0]        out_ch;
    logic signed [DSZ-1:0] out_i, out_q;

    complex_mixer_tdm #(.DSZ(DSZ), .NCH(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_i(in_i), .in_q(in_q), .lo_i(lo_i), .lo_q(lo_q),
        .conj(conj), .out_valid(out_valid), .out_ch(out_ch), .out_i(out_i), .out_q(out_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int ch;
        int ei;
        int eq;
        bit lit;
        int li;
        int lq;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = -100;
    int   hold_i = 0, hold_q = 0, hold_ch = 0;
    bit   mon_en = 1'b0;
    bit   drv_lit = 1'b0;
    int   drv_li = 0, drv_lq = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rsat(input longint x);
        longint r;
        r = (x + 64'sd16384) >>> 15;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    // Reference: full-precision complex multiply, conj applied only when enabled.
    function automatic void mix(input int xi, input int xq, input int li, input int lq,
                                input bit cj, output int oi, output int oq);
        longint ii, qq, iq, qi;
        bit c;
`ifdef COMPLEX_MIXER_CONJ_EN
        c = cj;
`else
        c = 1'b0;
`endif
        ii = longint'(xi) * longint'(li);
        qq = longint'(xq) * longint'(lq);
        iq = longint'(xi) * longint'(lq);
        qi = longint'(xq) * longint'(li);
        oi = rsat(c ? ii + qq : ii - qq);
        oq = rsat(c ? qi - iq : iq + qi);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Compare process: every cycle checks in_ready, out_valid timing and values.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            bit   due;
            int   oi, oq;
            chk("in_ready", int'(in_ready), int'(!reset && (cyc - last_acc >= 4)));
            due = (q.size() > 0) && (q[0].due == cyc);
            chk("out_valid", int'(out_valid), int'(due));
            if (due) begin
                e = q.pop_front();
                if (out_valid) begin
                    chk("out_ch", int'(out_ch), e.ch);
                    chk("out_i", int'(out_i), e.ei);
                    chk("out_q", int'(out_q), e.eq);
                    if (e.lit) begin
                        chk("lit_i", int'(out_i), e.li);
                        chk("lit_q", int'(out_q), e.lq);
                    end
                    hold_i = e.ei; hold_q = e.eq; hold_ch = e.ch;
                end
            end else begin
                chk("hold_i", int'(out_i), hold_i);
                chk("hold_q", int'(out_q), hold_q);
                chk("hold_ch", int'(out_ch), hold_ch);
            end
            if (in_valid && in_ready) begin
                mix(int'(in_i), int'(in_q), int'(lo_i), int'(lo_q), conj, oi, oq);
                e.due = cyc + 6; e.ch = int'(in_ch); e.ei = oi; e.eq = oq;
                e.lit = drv_lit; e.li = drv_li; e.lq = drv_lq;
                q.push_back(e);
                last_acc = cyc;
            end
            if (reset) begin
                q.delete();
                last_acc = -100;
                hold_i = 0; hold_q = 0; hold_ch = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present one sample and wait (bounded) until it is accepted.
    task automatic send(input int ch, input int xi, input int xq, input int li, input int lq,
                        input bit cj, input bit lit, input int ei, input int eq);
        int n = 0;
        in_ch = CHW'(ch); in_i = 16'(xi); in_q = 16'(xq); lo_i = 16'(li); lo_q = 16'(lq);
        conj = cj; drv_lit = lit; drv_li = ei; drv_lq = eq;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout at cycle %0d: in_ready stuck at 0", cyc);
        end
        step();
        in_valid = 1'b0;
        drv_lit = 1'b0;
    endtask

    task automatic rnd_sample();
        int v[4];
        for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 5))
                0:       v[k] = -32768;
                1:       v[k] = 32767;
                default: v[k] = int'($urandom_range(0, 65535)) - 32768;
            endcase
        end
        in_i = 16'(v[0]); in_q = 16'(v[1]); lo_i = 16'(v[2]); lo_q = 16'(v[3]);
        conj = 1'($urandom_range(0, 1));
    endtask

    initial begin
        bit rdy_prev;
        int c_exp;
        reset = 1'b1; in_valid = 1'b0; in_ch = '0; conj = 1'b0;
        in_i = '0; in_q = '0; lo_i = '0; lo_q = '0;
        step(); step();
        mon_en = 1'b1;
        step();
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_i", int'(out_i), 0);
        reset = 1'b0;
        step();

        // Directed cases with hand-computed results.
        send(1, 16384, 0, 16384, 0, 1'b0, 1'b1, 8192, 0);
        repeat (8) step();
        send(0, -32768, -32768, -32768, -32768, 1'b0, 1'b1, 0, 32767);
        repeat (8) step();
        send(1, 0, 16384, 0, 16384, 1'b0, 1'b1, -8192, 0);
        repeat (8) step();
`ifdef COMPLEX_MIXER_CONJ_EN
        c_exp = 8192;
`else
        c_exp = -8192;
`endif
        send(0, 0, 16384, 0, 16384, 1'b1, 1'b1, c_exp, 0);
        repeat (8) step();
        send(1, 1, 0, 16384, 0, 1'b0, 1'b1, 1, 0);
        send(0, -1, 0, 16384, 0, 1'b0, 1'b1, 0, 0);
        repeat (8) step();

        // in_valid held high continuously; channel toggles per accepted sample.
        in_ch = '0; rnd_sample(); in_valid = 1'b1;
        rdy_prev = in_ready;
        for (int n = 0; n < 48; n++) begin
            step();
            if (rdy_prev) begin
                in_ch = ~in_ch;
                rnd_sample();
            end
            rdy_prev = in_ready;
        end
        in_valid = 1'b0;
        repeat (8) step();

        // Random traffic with random gaps.
        for (int n = 0; n < 40; n++) begin
            in_ch = CHW'($urandom_range(0, 1));
            rnd_sample();
            in_valid = 1'b1;
            while (!in_ready) step();
            step();
            in_valid = 1'b0;
            repeat ($urandom_range(0, 6)) step();
        end
        repeat (8) step();

        // Reset three cycles after an accept: the in-flight sample must vanish.
        send(1, 12000, -5000, 20000, 7000, 1'b0, 1'b0, 0, 0);
        step();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        repeat (10) step();
        chk("post_reset_out_i", int'(out_i), 0);
        chk("post_reset_out_q", int'(out_q), 0);
        send(0, 16384, 0, 16384, 0, 1'b0, 1'b1, 8192, 0);
        repeat (10) step();

        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/complex_mixer_tdm.md
# complex_mixer_tdm

Parametrised complex mixer for the receive/transmit DSP chain. It multiplies a complex sample by a complex LO sample, optionally using the conjugate of the LO, for up to NCH time-multiplexed channels. One shared multiplier performs the four partial products over four cycles. Valid/ready handshaking replaces the old free-running 4-cycle strobe, and channel tags pass through with the data.

## Interface
- DSZ, 16: data and LO word width, signed fixed point with DSZ-1 fractional bits.
- NCH, 2: number of channels. Tag width CHW = max(1, clog2(NCH)).
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_ch  in  CHW  channel tag of the input sample.
- in_i, in_q  in  DSZ  signed input sample.
- lo_i, lo_q  in  DSZ  signed LO sample.
- conj  in  1  1 selects in*conj(lo), 0 selects in*lo. Sampled on accept.
- out_valid  out  1  one-cycle pulse when a result is available.
- out_ch  out  CHW  channel tag of the result.
- out_i, out_q  out  DSZ  signed result. Held between pulses.

## Operation
- Accept occurs when in_valid && in_ready. On accept the block captures in_i, in_q, lo_i, lo_q, in_ch and conj into operand buffers.
- States: IDLE, PH0, PH1, PH2, PH3.
  - Accept from IDLE moves to PH0.
  - Each phase advances by one state per cycle.
  - From PH3: an accept goes to PH0, otherwise the block returns to IDLE.
- in_ready = (state == IDLE || state == PH3) && !reset. No other input is registered.
- Multiplier operands per phase: PH0 in_i*lo_i, PH1 in_q*lo_q, PH2 in_i*lo_q, PH3 in_q*lo_i. Each is a full 2*DSZ-bit signed product, registered.
- Accumulation uses full precision, 2*DSZ+1 bits, with no intermediate rounding:
  - conj=0: I = ii - qq, Q = iq + qi.
  - conj=1: I = ii + qq, Q = qi - iq.
- Output scaling: out = sat_DSZ((acc + 2^(DSZ-2)) >>> (DSZ-1)). This is round half up, followed by saturation to [-2^(DSZ-1), 2^(DSZ-1)-1].
- out_ch and the conj selection travel with their sample through the pipeline. A new accept never corrupts a sample already in flight.
- There is no output backpressure. The downstream block always consumes out_valid.
- Channels are only tags. The block keeps no per-channel state, so samples from any channel may be interleaved.
- The block does not reorder samples. Outputs appear in accept order.

## Timing
- Reset values: out_valid 0, out_i 0, out_q 0, out_ch 0, state IDLE. in_ready is 0 during reset and 1 in the first cycle after reset deasserts.
- Latency: if the accept happens at cycle T, out_valid is 1 at cycle T+6, with result and tag valid in that same cycle.
- Throughput: one sample every 4 cycles. With back-to-back accepts at T and T+4, outputs appear at T+6 and T+10.
- An accept is only possible in IDLE or PH3. in_valid asserted in PH0 to PH2 is ignored and the sample is not consumed.
- Reset mid-operation drops all in-flight samples. No out_valid is produced for them in any later cycle.
- out_i, out_q and out_ch change only in the cycle where out_valid is 1.

## Configuration
- COMPLEX_MIXER_CONJ_EN defined: the conj port is honoured per sample as described above.
- COMPLEX_MIXER_CONJ_EN undefined: the conj port stays in the interface but is ignored and treated as 0, and the conj=1 accumulation path is not synthesised.

## Test plan
All scenarios use DSZ=16 and NCH=2.
- Basic product: in=(16384,0), lo=(16384,0), conj=0, ch=1, accepted at T. Required: out_valid at T+6 with out=(8192,0) and out_ch=1.
- Saturation: in=(-32768,-32768), lo=(-32768,-32768), conj=0. Required: out=(0,32767), since Q=2^31 saturates.
- Conjugate mode: in=(0,16384), lo=(0,16384).
  - conj=0 gives (-8192,0).
  - conj=1 gives (8192,0) with the macro defined and (-8192,0) without it.
- Rounding: in=(1,0), lo=(16384,0) gives out_i=1. in=(-1,0), lo=(16384,0) gives out_i=0.
- Back-to-back and handshake: hold in_valid high continuously with alternating channels 0 and 1.
  - Required: accepts every 4 cycles, outputs every 4 cycles in order with correct tags, and in_ready low during PH0 to PH2.
- Reset mid-operation: assert reset 3 cycles after an accept. Required: no out_valid follows, outputs are 0, and in_ready returns to 1 the cycle after reset deasserts.
